// File: rtl/range_accum.sv
// Range accumulator: folds elements lo..hi of a captured vector with sum, max, min or xor.
// One element is accumulated per clock. The result is pulsed with done and then held.
module range_accum #(
    parameter  int W  = 4,
    parameter  int N  = 8,
    localparam int IW = $clog2(N),
    localparam int RW = W + IW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W*N-1:0]    data_in,
    input  logic [IW-1:0]     bound_a,
    input  logic [IW-1:0]     bound_b,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [RW-1:0]     result
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [IW-1:0] MAXI = IW'(N - 1);

    state_t               state;
    logic [N-1:0][W-1:0]  din, cap;
    logic [1:0]           cap_mode;
    logic [IW-1:0]        idx, hi, idx_nx;
    logic [IW-1:0]        ca, cb, lo_in, hi_in;
    logic                 oob_a, oob_b;
    logic [RW-1:0]        acc, step;
    logic [W-1:0]         elem;

    assign din = data_in;

    // Bounds past the last element only occur for non-power-of-two N.
    assign oob_a  = {1'b0, bound_a} >= (IW+1)'(N);
    assign oob_b  = {1'b0, bound_b} >= (IW+1)'(N);
    assign ca     = oob_a ? MAXI : bound_a;
    assign cb     = oob_b ? MAXI : bound_b;
    assign lo_in  = (ca < cb) ? ca : cb;
    assign hi_in  = (ca < cb) ? cb : ca;

    assign idx_nx = idx + IW'(1);
    assign elem   = cap[idx_nx];
    assign busy   = (state != IDLE);

    // In max/min/xor modes the accumulator only ever holds a zero-extended W-bit value.
    always_comb begin
        step = acc;
        case (cap_mode)
            2'b00:   step = acc + RW'(elem);
            2'b01:   step = (elem > acc[W-1:0]) ? RW'(elem) : acc;
            2'b10:   step = (elem < acc[W-1:0]) ? RW'(elem) : acc;
            default: step = RW'(acc[W-1:0] ^ elem);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            acc      <= '0;
            cap      <= '0;
            cap_mode <= 2'b00;
            idx      <= '0;
            hi       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap      <= din;
                        cap_mode <= mode;
                        idx      <= lo_in;
                        hi       <= hi_in;
                        acc      <= RW'(din[lo_in]);
                        err      <= oob_a | oob_b;
                        if (lo_in == hi_in) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= RW'(din[lo_in]);
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        result <= '0;
                        err    <= 1'b0;
                    end else begin
                        idx <= idx_nx;
                        acc <= step;
                        if (idx_nx == hi) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= step;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_accum.sv
// Bench for range_accum: an N=8 and an N=6 instance, a vector table,
// hand-written abort/reset/start-hold sequences and a randomized run against a range model.
module tb_range_accum;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] din8 = '0;
    logic [23:0] din6 = '0;
    logic [2:0]  ba8 = '0, bb8 = '0, ba6 = '0, bb6 = '0;
    logic [1:0]  md8 = '0, md6 = '0;
    logic        st8 = 1'b0, st6 = 1'b0, ab8 = 1'b0, ab6 = 1'b0;
    logic        busy8, done8, err8, busy6, done6, err6;
    logic [6:0]  res8, res6;

    range_accum #(.W(4), .N(8)) dut8 (
        .clk(clk), .rst(rst), .data_in(din8), .bound_a(ba8), .bound_b(bb8), .mode(md8),
        .start(st8), .abort(ab8), .busy(busy8), .done(done8), .err(err8), .result(res8));

    range_accum #(.W(4), .N(6)) dut6 (
        .clk(clk), .rst(rst), .data_in(din6), .bound_a(ba6), .bound_b(bb6), .mode(md6),
        .start(st6), .abort(ab6), .busy(busy6), .done(done6), .err(err6), .result(res6));

    int n_cmp = 0, n_bad = 0;
    int dcnt8 = 0, dcnt6 = 0;

    // done is counted at the rising edge, i.e. once per cycle in which it was high
    always @(posedge clk) begin
        if (done8 === 1'b1) dcnt8++;
        if (done6 === 1'b1) dcnt6++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Fold of elements min..max of the clamped bounds, straight from the rules.
    function automatic logic [31:0] model(input logic [31:0] data, input int n, input int a,
                                          input int b, input logic [1:0] m,
                                          output int lat, output logic e);
        int ca, cb, lo, hi, acc, x;
        e   = (a >= n) || (b >= n);
        ca  = (a >= n) ? n - 1 : a;
        cb  = (b >= n) ? n - 1 : b;
        lo  = (ca < cb) ? ca : cb;
        hi  = (ca < cb) ? cb : ca;
        acc = int'((data >> (4 * lo)) & 32'hF);
        for (int i = lo + 1; i <= hi; i++) begin
            x = int'((data >> (4 * i)) & 32'hF);
            case (m)
                2'd0:    acc = acc + x;
                2'd1:    if (x > acc) acc = x;
                2'd2:    if (x < acc) acc = x;
                default: acc = acc ^ x;
            endcase
        end
        lat = hi - lo + 1;
        return 32'(acc);
    endfunction

    task automatic drive(input bit sel, input logic [31:0] d, input int a, input int b,
                         input int m, input logic s);
        if (sel) begin
            din6 = d[23:0]; ba6 = 3'(a); bb6 = 3'(b); md6 = 2'(m); st6 = s;
        end else begin
            din8 = d; ba8 = 3'(a); bb8 = 3'(b); md8 = 2'(m); st8 = s;
        end
    endtask

    task automatic set_start(input bit sel, input logic s);
        if (sel) st6 = s; else st8 = s;
    endtask

    // One operation: start, wait (bounded) for done, check latency/result/err, then pulse width and hold.
    task automatic op(input bit sel, input logic [31:0] data, input int a, input int b,
                      input logic [1:0] m, input bit scr, input string nm,
                      input logic [31:0] exp_r, input int exp_lat, input logic exp_e);
        int lat;
        logic [31:0] r;
        logic e;
        lat = 0; r = 'x; e = 1'bx;
        @(negedge clk);
        drive(sel, data, a, b, int'(m), 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) chk({nm, " busy"}, 32'(sel ? busy6 : busy8), 32'd1);
            if ((sel ? done6 : done8) === 1'b1) begin
                lat = k;
                r   = 32'(sel ? res6 : res8);
                e   = sel ? err6 : err8;
                break;
            end
            // inputs and start churn while busy; the captured operation must not notice
            if (scr) drive(sel, $urandom, int'($urandom_range(7)), int'($urandom_range(7)),
                           int'($urandom_range(3)), 1'($urandom));
            @(negedge clk);
        end
        set_start(sel, 1'b0);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " result"}, r, exp_r);
        chk({nm, " err"}, 32'(e), 32'(exp_e));
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(sel ? done6 : done8), 32'd0);
        chk({nm, " hold"}, 32'(sel ? res6 : res8), exp_r);
        chk({nm, " idle"}, 32'(sel ? busy6 : busy8), 32'd0);
    endtask

    typedef struct {
        bit          sel;
        logic [31:0] data;
        int          a;
        int          b;
        logic [1:0]  m;
        logic [31:0] r;
        int          lat;
        logic        e;
    } vec_t;

    localparam logic [31:0] D8 = 32'h87654321;
    localparam logic [31:0] D6 = 32'h00654321;

    vec_t tbl[13];

    initial begin
        int c0, lat;
        logic e;
        logic [31:0] r, d;
        bit sel;
        int a, b;
        logic [1:0] m;

        tbl[0]  = '{1'b0, D8, 5, 2, 2'd0, 32'h12, 4, 1'b0};
        tbl[1]  = '{1'b0, D8, 0, 7, 2'd1, 32'd8,  8, 1'b0};
        tbl[2]  = '{1'b0, D8, 6, 3, 2'd2, 32'd4,  4, 1'b0};
        tbl[3]  = '{1'b0, D8, 0, 0, 2'd0, 32'd1,  1, 1'b0};
        tbl[4]  = '{1'b0, D8, 1, 4, 2'd3, 32'd0,  4, 1'b0};
        tbl[5]  = '{1'b0, D8, 7, 7, 2'd0, 32'd8,  1, 1'b0};
        tbl[6]  = '{1'b0, D8, 0, 7, 2'd0, 32'd36, 8, 1'b0};
        tbl[7]  = '{1'b0, D8, 3, 1, 2'd3, 32'd5,  3, 1'b0};
        tbl[8]  = '{1'b1, D6, 7, 4, 2'd0, 32'd11, 2, 1'b1};
        tbl[9]  = '{1'b1, D6, 6, 6, 2'd0, 32'd6,  1, 1'b1};
        tbl[10] = '{1'b1, D6, 1, 3, 2'd0, 32'd9,  3, 1'b0};
        tbl[11] = '{1'b1, D6, 5, 0, 2'd1, 32'd6,  6, 1'b0};
        tbl[12] = '{1'b1, D6, 0, 7, 2'd2, 32'd1,  6, 1'b1};

        // reset state
        #1;
        chk("rst busy8", 32'(busy8), 0); chk("rst done8", 32'(done8), 0);
        chk("rst err8", 32'(err8), 0);   chk("rst res8", 32'(res8), 0);
        chk("rst busy6", 32'(busy6), 0); chk("rst res6", 32'(res6), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i])
            op(tbl[i].sel, tbl[i].data, tbl[i].a, tbl[i].b, tbl[i].m, 1'b0,
               $sformatf("vec%0d", i), tbl[i].r, tbl[i].lat, tbl[i].e);

        // start held through RUN and DONE edges: one done only
        c0 = dcnt8;
        @(negedge clk); drive(0, D8, 0, 7, 0, 1'b1);
        repeat (9) @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_start dones", 32'(dcnt8 - c0), 1);
        chk("hold_start res", 32'(res8), 36);

        c0 = dcnt8;
        drive(0, D8, 0, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        st8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_start1 dones", 32'(dcnt8 - c0), 1);
        chk("hold_start1 res", 32'(res8), 1);

        // abort at the edge after E0
        c0 = dcnt8;
        drive(0, D8, 1, 4, 3, 1'b1);
        @(negedge clk); st8 = 1'b0; ab8 = 1'b1;
        @(negedge clk); ab8 = 1'b0;
        chk("abort busy", 32'(busy8), 0);
        chk("abort res", 32'(res8), 0);
        chk("abort err", 32'(err8), 0);
        repeat (4) @(negedge clk);
        chk("abort dones", 32'(dcnt8 - c0), 0);

        // abort on the completing edge wins
        op(0, D8, 7, 7, 2'd0, 1'b0, "pre_prio", 8, 1, 1'b0);
        c0 = dcnt8;
        drive(0, D8, 2, 3, 0, 1'b1);
        @(negedge clk); st8 = 1'b0; ab8 = 1'b1;
        @(negedge clk); ab8 = 1'b0;
        chk("prio res", 32'(res8), 0);
        chk("prio busy", 32'(busy8), 0);
        repeat (2) @(negedge clk);
        chk("prio dones", 32'(dcnt8 - c0), 0);

        // abort while idle is ignored
        op(0, D8, 7, 7, 2'd0, 1'b0, "pre_idle_abort", 8, 1, 1'b0);
        c0 = dcnt8;
        ab8 = 1'b1;
        repeat (2) @(negedge clk);
        ab8 = 1'b0;
        chk("idle_abort res", 32'(res8), 8);
        chk("idle_abort dones", 32'(dcnt8 - c0), 0);

        // start and abort together in IDLE: start wins
        drive(0, D8, 0, 1, 0, 1'b1); ab8 = 1'b1;
        @(negedge clk); st8 = 1'b0; ab8 = 1'b0;
        chk("start_abort busy", 32'(busy8), 1);
        @(negedge clk);
        chk("start_abort done", 32'(done8), 1);
        chk("start_abort res", 32'(res8), 3);
        @(negedge clk);

        // abort clears a latched clamp error
        op(1, D6, 7, 4, 2'd0, 1'b0, "pre_err_abort", 11, 2, 1'b1);
        drive(1, D6, 7, 0, 0, 1'b1);
        @(negedge clk); st6 = 1'b0; ab6 = 1'b1;
        @(negedge clk); ab6 = 1'b0;
        chk("err_abort err", 32'(err6), 0);
        chk("err_abort res", 32'(res6), 0);

        // asynchronous reset mid-RUN
        op(0, D8, 7, 7, 2'd0, 1'b0, "pre_rst", 8, 1, 1'b0);
        c0 = dcnt8;
        drive(0, D8, 0, 7, 0, 1'b1);
        @(negedge clk); st8 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst busy", 32'(busy8), 0); chk("midrst done", 32'(done8), 0);
        chk("midrst err", 32'(err8), 0);   chk("midrst res", 32'(res8), 0);
        @(negedge clk); rst = 1'b1;
        op(0, D8, 7, 7, 2'd0, 1'b0, "post_rst", 8, 1, 1'b0);
        chk("midrst dones", 32'(dcnt8 - c0), 1);

        // randomized operations against the model, with inputs churning during RUN
        for (int i = 0; i < 60; i++) begin
            sel = 1'($urandom);
            d   = $urandom;
            if (sel) d[31:24] = 8'h00;
            a   = int'($urandom_range(7));
            b   = int'($urandom_range(7));
            m   = 2'($urandom);
            r   = model(d, sel ? 6 : 8, a, b, m, lat, e);
            op(sel, d, a, b, m, 1'b1, $sformatf("rnd%0d", i), r, lat, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
